mont_exp_ctrl: RTL and testbench
================================

# mont_exp_ctrl

Modular exponentiation sequencer for the RSA datapath. It computes X^E mod M using left-to-right square-and-multiply. It acts as the initiator on the `montgomery` multiplier's start/done handshake: it drives operands and a `start` pulse, waits for `done`, and captures `result`. It sits between the top-level RSA control and one external `montgomery` instance, and contains no arithmetic of its own.

## Interface
- `WIDTH`, 1024: operand and modulus width in bits.
- `EXP_WIDTH`, 1024: exponent register width in bits.
- `clk` in 1: clock; all logic acts on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `in_x_tilde` in WIDTH: base in Montgomery domain (X·R mod M).
- `in_r` in WIDTH: R mod M (Montgomery one).
- `in_m` in WIDTH: modulus; odd.
- `in_e` in EXP_WIDTH: exponent.
- `in_e_len` in clog2(EXP_WIDTH+1): number of exponent bits to process, from 0 to EXP_WIDTH.
- `mul_start` out 1: one-cycle pulse to the multiplier's `start`.
- `mul_a` out WIDTH: multiplier operand A.
- `mul_b` out WIDTH: multiplier operand B.
- `mul_m` out WIDTH: multiplier modulus.
- `mul_result` in WIDTH: multiplier `result`.
- `mul_done` in 1: multiplier `done` pulse.
- `result` out WIDTH: X^E mod M in normal domain.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, POST_ISSUE, POST_WAIT, DONE.
- **IDLE, on `start`:**
  - Latch `in_x_tilde`, `in_m`, `in_e` and `in_e_len`.
  - Set accumulator A := `in_r` and bit index i := `in_e_len`−1.
  - Go to SQR_ISSUE, or to POST_ISSUE if `in_e_len`=0.
- **SQR_ISSUE:** `mul_a`=`mul_b`=A; assert `mul_start`; go to SQR_WAIT.
- **SQR_WAIT:** on `mul_done`, A := `mul_result`.
  - If e[i]=1, go to MUL_ISSUE.
  - Otherwise, if i=0 go to POST_ISSUE; else decrement i and go to SQR_ISSUE.
- **MUL_ISSUE:** `mul_a`=A, `mul_b`=X̃; assert `mul_start`; go to MUL_WAIT.
- **MUL_WAIT:** on `mul_done`, A := `mul_result`. If i=0 go to POST_ISSUE; else decrement i and go to SQR_ISSUE.
- **POST_ISSUE:** `mul_a`=A, `mul_b`=1 (zero-extended); assert `mul_start`; go to POST_WAIT.
- **POST_WAIT:** on `mul_done`, `result` := `mul_result`; go to DONE.
- **DONE:** assert `done` for one cycle; go to IDLE.
- **Operand stability:** `mul_a`, `mul_b` and `mul_m` are registered. They are stable from the ISSUE cycle through the matching `mul_done` cycle. `mul_m` always equals the latched M.
- **Handshake rules:**
  - `mul_done` is ignored outside the WAIT states.
  - `start` is ignored while `busy`=1.
  - Bits of `in_e` at positions ≥ `in_e_len` are ignored.
- **`result` hold:** `result` holds its value until the next POST_WAIT capture. Inputs may change after the `start` cycle without effect.
- **Operation count:** N_ops = `in_e_len` + popcount(e[`in_e_len`−1:0]) + 1.

## Timing
- **Reset values:** `mul_start`=0, `done`=0, `busy`=0, `result`=0, `mul_a`=`mul_b`=`mul_m`=0, state=IDLE.
- **Reset mid-operation:** on the next edge the block returns to IDLE with all outputs at reset values. No `done` is produced for the aborted operation.
- **Start to first issue:** `start` is sampled high in cycle 0; `busy`=1 and the first ISSUE happen in cycle 1.
- **Multiplier latency:** if `mul_done` follows `mul_start` by L cycles (L≥1), each operation occupies L+1 cycles. The next ISSUE is in the cycle after `mul_done`.
- **Completion:** `done` is high in cycle 1 + N_ops·(L+1), and `result` is valid in that same cycle. `busy` falls in the following cycle.
- **Back-to-back starts:** a `start` in the cycle after `done` is accepted.
- **`mul_start` width:** never high in two consecutive cycles.

## Test plan
Bench uses a behavioural multiplier stub computing a·b·2^-1024 mod m with a programmable L. All values are 1024-bit, and R mod 13 = 3.

- **Basic exponent:** m=13, X̃=6 (x=2), in_r=3, e=5, e_len=3, L=3 → `result`=6; `done` in cycle 25; 6 `mul_start` pulses.
- **Zero exponent:** e=0, e_len=1, same m/X̃/in_r, L=3 → `result`=1; `done` in cycle 9.
- **Empty exponent:** e_len=0 → a single POST operation; `result`=1; `done` in cycle 5.
- **Latency and bit masking:** L=1 and then L=17, with e=0xFFFF but e_len=4 (effective e=0xF) → `result`=2^15 mod 13=8 for both. `done` in cycle 19 for L=1 and cycle 163 for L=17.
- **Start while busy:** a second `start` is pulsed during SQR_WAIT → it is ignored; exactly one `done`; `result` unchanged from the first run.
- **Reset mid-operation:** `resetn`=0 for one cycle during MUL_WAIT → all outputs at reset values the next cycle. A late `mul_done` is ignored. A new `start` then completes correctly.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
// Start/done handshake bus between the exponentiation sequencer and one
// Montgomery multiplier. The sequencer is the master and the multiplier is the slave.
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 1024
) ();
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;

    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer that computes X^E mod M.
// It drives an external Montgomery multiplier through the mul bus. The
// accumulator lives in mul_a_q: every multiplier result is loaded into mul_a_q
// at the same moment that the next operation is issued.
module mont_exp_ctrl #(
    parameter  int WIDTH     = 1024,
    parameter  int EXP_WIDTH = 1024,
    localparam int LW        = $clog2(EXP_WIDTH + 1),
    localparam int IW        = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x_tilde,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LW-1:0]        in_e_len,
    mont_exp_ctrl_if.master      mul,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, POST_ISSUE, POST_WAIT, DONE
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [IW-1:0]        i_q, i_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     mul_m_q, mul_m_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 e_bit;
    logic                 last_bit;

    assign e_bit    = e_q[i_q];
    assign last_bit = (i_q == '0);

    // State and datapath registers. The reset is synchronous and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= '0;
            e_q      <= '0;
            i_q      <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_m_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            e_q      <= e_d;
            i_q      <= i_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_m_q  <= mul_m_d;
            result_q <= result_d;
        end
    end

    // Next-state logic. The WAIT states advance only on mul_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = (in_e_len == '0) ? POST_ISSUE : SQR_ISSUE;
            SQR_ISSUE:  state_d = SQR_WAIT;
            SQR_WAIT:   if (mul.mul_done) begin
                            if (e_bit)         state_d = MUL_ISSUE;
                            else if (last_bit) state_d = POST_ISSUE;
                            else               state_d = SQR_ISSUE;
                        end
            MUL_ISSUE:  state_d = MUL_WAIT;
            MUL_WAIT:   if (mul.mul_done) state_d = last_bit ? POST_ISSUE : SQR_ISSUE;
            POST_ISSUE: state_d = POST_WAIT;
            POST_WAIT:  if (mul.mul_done) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath updates. The operands for the next ISSUE are loaded on the
    // edge that enters it, so they stay stable until the matching mul_done.
    always_comb begin
        x_d      = x_q;
        e_d      = e_q;
        i_d      = i_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        mul_m_d  = mul_m_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                x_d     = in_x_tilde;
                e_d     = in_e;
                mul_m_d = in_m;
                i_d     = IW'(in_e_len - LW'(1));
                mul_a_d = in_r;
                mul_b_d = (in_e_len == '0) ? ONE : in_r;
            end
            SQR_WAIT: if (mul.mul_done) begin
                mul_a_d = mul.mul_result;
                if (e_bit) begin
                    mul_b_d = x_q;
                end else if (last_bit) begin
                    mul_b_d = ONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    mul_b_d = mul.mul_result;
                end
            end
            MUL_WAIT: if (mul.mul_done) begin
                mul_a_d = mul.mul_result;
                if (last_bit) begin
                    mul_b_d = ONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    mul_b_d = mul.mul_result;
                end
            end
            POST_WAIT: if (mul.mul_done) result_d = mul.mul_result;
            default: ;
        endcase
    end

    // Outputs decoded from the state. The ISSUE states each last exactly one cycle.
    always_comb begin
        mul.mul_start = (state_q == SQR_ISSUE) || (state_q == MUL_ISSUE) ||
                        (state_q == POST_ISSUE);
        done          = (state_q == DONE);
        busy          = (state_q != IDLE);
    end

    assign mul.mul_a = mul_a_q;
    assign mul.mul_b = mul_b_q;
    assign mul.mul_m = mul_m_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl. A behavioural Montgomery multiplier
// (a*b*2^-1024 mod m) with programmable latency plays the slave side.
module tb_mont_exp_ctrl;
    localparam int W = 1024;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic [W-1:0]   in_x_tilde, in_r, in_m, in_e;
    logic [10:0]    in_e_len;
    logic [W-1:0]   result;
    logic           done, busy;

    mont_exp_ctrl_if #(.WIDTH(W)) mif ();

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_x_tilde (in_x_tilde),
        .in_r       (in_r),
        .in_m       (in_m),
        .in_e       (in_e),
        .in_e_len   (in_e_len),
        .mul        (mif),
        .result     (result),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Multiplier stub state
    int           lat = 3;
    int           cnt = 0;
    logic         sd_q = 1'b0;
    logic [W-1:0] sres_q = '0;
    logic [W-1:0] la, lb, lm;
    logic         pend = 1'b0;
    int           stab_err = 0;
    int           ms_err = 0;
    logic         prev_ms = 1'b0;
    int           npulse = 0;
    int           ndone = 0;

    assign mif.mul_done   = sd_q;
    assign mif.mul_result = sres_q;

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
        logic [W+1:0] t;
        t = '0;
        for (int k = 0; k < W; k++) begin
            if (a[k]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    // Multiplier stub: mul_done arrives lat cycles after mul_start. It also watches operand stability.
    always @(posedge clk) begin
        sd_q <= 1'b0;
        if (mif.mul_start) begin
            la     <= mif.mul_a;
            lb     <= mif.mul_b;
            lm     <= mif.mul_m;
            pend   <= 1'b1;
            sres_q <= mont(mif.mul_a, mif.mul_b, mif.mul_m);
            if (lat == 1) sd_q <= 1'b1;
            else          cnt  <= lat - 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) sd_q <= 1'b1;
        end
        if (pend && !mif.mul_start) begin
            if (mif.mul_a !== la || mif.mul_b !== lb || mif.mul_m !== lm)
                stab_err <= stab_err + 1;
            if (sd_q) pend <= 1'b0;
        end
        if (!resetn) pend <= 1'b0;
    end

    // Count start pulses and done pulses, and flag back-to-back mul_start.
    always @(posedge clk) begin
        prev_ms <= mif.mul_start;
        if (prev_ms && mif.mul_start) ms_err <= ms_err + 1;
        if (mif.mul_start) npulse <= npulse + 1;
        if (done) ndone <= ndone + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one operation from an idle cycle and follow it to completion.
    // Cycle 1 is the cycle after start is sampled. If poke is nonzero, start
    // is driven again during that cycle.
    task automatic run(input string tag, input logic [W-1:0] e, input logic [10:0] elen,
                       input int l, input logic [W-1:0] exp_res, input int exp_cyc,
                       input int exp_pulses, input int poke);
        int cyc, n0, d0;
        lat        = l;
        in_x_tilde = W'(6);
        in_r       = W'(3);
        in_m       = W'(13);
        in_e       = e;
        in_e_len   = elen;
        start      = 1'b1;
        n0 = npulse;
        d0 = ndone;
        @(posedge clk); #1;
        start      = 1'b0;
        in_e       = ~e;
        in_x_tilde = W'(7);
        in_r       = W'(11);
        in_m       = W'(17);
        in_e_len   = 11'd1;
        cyc = 1;
        chk({tag, ".busy1"}, W'(busy), W'(1));
        chk({tag, ".issue1"}, W'(mif.mul_start), W'(1));
        chk({tag, ".mul_m"}, mif.mul_m, W'(13));
        while (!done && cyc < 1000) begin
            start = (cyc == poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".done_cycle"}, W'(cyc), W'(exp_cyc));
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".pulses"}, W'(npulse - n0), W'(exp_pulses));
        @(posedge clk); #1;
        chk({tag, ".busy_after"}, W'(busy), W'(0));
        chk({tag, ".done_count"}, W'(ndone - d0), W'(1));
    endtask

    initial begin
        int cyc, d0;
        resetn     = 1'b0;
        start      = 1'b0;
        in_x_tilde = '0;
        in_r       = '0;
        in_m       = '0;
        in_e       = '0;
        in_e_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", W'(busy), W'(0));
        chk("rst.done", W'(done), W'(0));
        chk("rst.mul_start", W'(mif.mul_start), W'(0));
        chk("rst.result", result, W'(0));
        chk("rst.mul_a", mif.mul_a, W'(0));
        chk("rst.mul_b", mif.mul_b, W'(0));
        chk("rst.mul_m", mif.mul_m, W'(0));
        resetn = 1'b1;
        @(posedge clk); #1;

        // 2^5 mod 13 = 6. The ops are sqr,mul,sqr,sqr,mul,post.
        run("basic", W'(5), 11'd3, 3, W'(6), 25, 6, 0);
        // The next start is issued in the cycle right after done.
        run("zero_exp", W'(0), 11'd1, 3, W'(1), 9, 2, 0);
        run("empty_exp", W'(5), 11'd0, 3, W'(1), 5, 1, 0);
        // Exponent bits above e_len are ignored: effective e=0xF, 2^15 mod 13 = 8.
        run("lat1", W'(16'hFFFF), 11'd4, 1, W'(8), 19, 9, 0);
        run("lat17", W'(16'hFFFF), 11'd4, 17, W'(8), 163, 9, 0);
        // A second start during SQR_WAIT (cycle 3) is ignored.
        run("busy_start", W'(5), 11'd3, 3, W'(6), 25, 6, 3);
        d0 = ndone;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_start.no_extra_done", W'(ndone - d0), W'(0));
        chk("busy_start.result_hold", result, W'(6));

        // Reset during MUL_WAIT (cycle 6). The multiplier's done arrives late, in cycle 8.
        lat        = 3;
        in_x_tilde = W'(6);
        in_r       = W'(3);
        in_m       = W'(13);
        in_e       = W'(5);
        in_e_len   = 11'd3;
        start      = 1'b1;
        d0 = ndone;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            @(posedge clk); #1;
            cyc++;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("midrst.busy", W'(busy), W'(0));
        chk("midrst.done", W'(done), W'(0));
        chk("midrst.mul_start", W'(mif.mul_start), W'(0));
        chk("midrst.result", result, W'(0));
        chk("midrst.mul_a", mif.mul_a, W'(0));
        chk("midrst.mul_b", mif.mul_b, W'(0));
        chk("midrst.mul_m", mif.mul_m, W'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("midrst.idle_after_late_done", W'(busy), W'(0));
        chk("midrst.no_done", W'(ndone - d0), W'(0));
        run("after_rst", W'(5), 11'd3, 3, W'(6), 25, 6, 0);

        chk("mul_start_consecutive", W'(ms_err), W'(0));
        chk("operand_stability", W'(stab_err), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
